// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling, false-start
// rejection and framing-error detection with one-clock DV / error strobes.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 64
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Rx_Framing_Err,
   output logic       o_Rx_Active
);

   localparam int unsigned CountW = $clog2(CLKS_PER_BIT);
   localparam logic [CountW-1:0] Half = CountW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CountW-1:0] Last = CountW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StWaitHigh,
      StCleanup
   } state_e;

   state_e            state_q, state_d;
   logic              rx_meta_q, rx_s;
   logic [CountW-1:0] count_q, count_d;
   logic [2:0]        index_q, index_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        byte_d;
   logic              dv_d, err_d, active_d;

   // Synchroniser flops reset to the idle line level so reset cannot fake a start bit.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         rx_meta_q <= 1'b1;
         rx_s      <= 1'b1;
      end else begin
         rx_meta_q <= i_Rx_Serial;
         rx_s      <= rx_meta_q;
      end
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) state_q <= StIdle;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:     if (!rx_s) state_d = StStart;
         StStart:    if (count_q == Half) state_d = rx_s ? StIdle : StData;
         StData:     if (count_q == Last && index_q == 3'd7) state_d = StStop;
         StStop:     if (count_q == Last) state_d = rx_s ? StCleanup : StWaitHigh;
         StWaitHigh: if (rx_s) state_d = StCleanup;
         StCleanup:  state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   always_comb begin
      count_d  = count_q;
      index_d  = index_q;
      shift_d  = shift_q;
      byte_d   = o_Rx_Byte;
      dv_d     = 1'b0;
      err_d    = 1'b0;
      active_d = o_Rx_Active;
      case (state_q)
         StIdle: begin
            count_d = '0;
            index_d = 3'd0;
            if (!rx_s) active_d = 1'b1;
         end
         StStart: begin
            if (count_q == Half) begin
               count_d = '0;
               if (rx_s) active_d = 1'b0;
            end else begin
               count_d = count_q + CountW'(1);
            end
         end
         StData: begin
            if (count_q == Last) begin
               count_d          = '0;
               shift_d[index_q] = rx_s;
               index_d          = index_q + 3'd1;
            end else begin
               count_d = count_q + CountW'(1);
            end
         end
         StStop: begin
            if (count_q == Last) begin
               count_d = '0;
               if (rx_s) begin
                  byte_d = shift_q;
                  dv_d   = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               count_d = count_q + CountW'(1);
            end
         end
         StWaitHigh: ;
         StCleanup:  active_d = 1'b0;
         default: begin
            count_d  = '0;
            index_d  = 3'd0;
            active_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         count_q          <= '0;
         index_q          <= 3'd0;
         shift_q          <= 8'h00;
         o_Rx_Byte        <= 8'h00;
         o_Rx_DV          <= 1'b0;
         o_Rx_Framing_Err <= 1'b0;
         o_Rx_Active      <= 1'b0;
      end else begin
         count_q          <= count_d;
         index_q          <= index_d;
         shift_q          <= shift_d;
         o_Rx_Byte        <= byte_d;
         o_Rx_DV          <= dv_d;
         o_Rx_Framing_Err <= err_d;
         o_Rx_Active      <= active_d;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: expected bytes queued at send time, received
// bytes collected by a monitor, and each scenario task compares the two inline.
module tb_uart_rx;

   localparam int unsigned Cpb = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic       dv, err, active;
   logic [7:0] rx_byte;

   uart_rx #(.CLKS_PER_BIT(Cpb)) dut (
      .i_Clock         (clk),
      .i_Reset         (rst),
      .i_Rx_Serial     (rx),
      .o_Rx_DV         (dv),
      .o_Rx_Byte       (rx_byte),
      .o_Rx_Framing_Err(err),
      .o_Rx_Active     (active)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   int dv_cnt = 0, err_cnt = 0, overlap_cnt = 0, dv_cyc = 0, start_cyc = 0;
   int tests = 0, fails = 0;

   always @(negedge clk) begin
      if (dv) begin
         obs_q.push_back(rx_byte);
         dv_cnt = dv_cnt + 1;
         dv_cyc = cyc;
      end
      if (err) err_cnt = err_cnt + 1;
      if (dv && err) overlap_cnt = overlap_cnt + 1;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int clks);
      if (stop_bit) exp_q.push_back(data);
      start_cyc = cyc;
      rx = 1'b0;
      tick(clks);
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         tick(clks);
      end
      rx = stop_bit;
      tick(clks);
   endtask

   task automatic wait_obs(input int n, input string name);
      int budget;
      budget = 3000;
      while (obs_q.size() < n && budget > 0) begin
         tick(1);
         budget--;
      end
      if (obs_q.size() < n) begin
         tests++;
         fails++;
         $display("FAIL %s timeout: got %0d bytes, required %0d", name, obs_q.size(), n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(3);
      tests++; if (dv !== 1'b0) begin fails++; $display("FAIL reset_dv: got %b want 0", dv); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
      tests++; if (active !== 1'b0) begin fails++; $display("FAIL reset_active: got %b want 0", active); end
      tests++; if (rx_byte !== 8'h00) begin fails++; $display("FAIL reset_byte: got %h want 00", rx_byte); end
      rst = 1'b0;
      tick(10);
      tests++; if (active !== 1'b0) begin fails++; $display("FAIL idle_active: got %b want 0", active); end
   endtask

   task automatic test_single();
      int d0, e0, lat;
      logic [7:0] e, g;
      d0 = dv_cnt; e0 = err_cnt;
      send_frame(8'hA5, 1'b1, Cpb);
      tick(20);
      wait_obs(1, "single");
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); g = obs_q.pop_front();
         tests++; if (g !== e) begin fails++; $display("FAIL single_byte: got %h want %h", g, e); end
      end
      tests++; if (dv_cnt - d0 != 1) begin fails++; $display("FAIL single_dv_count: got %0d want 1", dv_cnt - d0); end
      tests++; if (err_cnt != e0) begin fails++; $display("FAIL single_err: got %0d want 0", err_cnt - e0); end
      lat = dv_cyc - start_cyc;
      tests++;
      if (lat < 608 || lat > 612) begin
         fails++; $display("FAIL single_latency: got %0d want 608..612", lat);
      end
   endtask

   task automatic test_back_to_back();
      int d0;
      logic [7:0] e, g;
      d0 = dv_cnt;
      send_frame(8'h00, 1'b1, Cpb);
      send_frame(8'hFF, 1'b1, Cpb);
      send_frame(8'h3C, 1'b1, Cpb);
      tick(20);
      wait_obs(3, "b2b");
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); g = obs_q.pop_front();
         tests++; if (g !== e) begin fails++; $display("FAIL b2b_byte: got %h want %h", g, e); end
      end
      tests++; if (dv_cnt - d0 != 3) begin fails++; $display("FAIL b2b_dv_count: got %0d want 3", dv_cnt - d0); end
   endtask

   task automatic test_false_start();
      int d0, e0;
      logic [7:0] e, g;
      tick(50);
      d0 = dv_cnt; e0 = err_cnt;
      rx = 1'b0;
      tick(10);
      tests++; if (active !== 1'b1) begin fails++; $display("FAIL glitch_active_hi: got %b want 1", active); end
      tick(10);
      rx = 1'b1;
      tick(30);
      tests++; if (active !== 1'b0) begin fails++; $display("FAIL glitch_active_lo: got %b want 0", active); end
      tests++; if (dv_cnt != d0 || err_cnt != e0) begin
         fails++; $display("FAIL glitch_pulses: got dv %0d err %0d want 0 0", dv_cnt - d0, err_cnt - e0);
      end
      send_frame(8'h55, 1'b1, Cpb);
      tick(20);
      wait_obs(1, "after_glitch");
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); g = obs_q.pop_front();
         tests++; if (g !== e) begin fails++; $display("FAIL after_glitch_byte: got %h want %h", g, e); end
      end
   endtask

   task automatic test_framing();
      int d0, e0;
      logic [7:0] e, g;
      tick(50);
      d0 = dv_cnt; e0 = err_cnt;
      send_frame(8'h3C, 1'b0, Cpb);
      tick(1000);
      tests++; if (active !== 1'b1) begin fails++; $display("FAIL break_active: got %b want 1", active); end
      tick(1000);
      tests++; if (err_cnt - e0 != 1) begin fails++; $display("FAIL framing_err_count: got %0d want 1", err_cnt - e0); end
      tests++; if (dv_cnt != d0) begin fails++; $display("FAIL framing_dv: got %0d want 0", dv_cnt - d0); end
      tests++; if (rx_byte !== 8'h55) begin fails++; $display("FAIL framing_byte_kept: got %h want 55", rx_byte); end
      rx = 1'b1;
      tick(100);
      tests++; if (active !== 1'b0) begin fails++; $display("FAIL framing_active_lo: got %b want 0", active); end
      send_frame(8'h81, 1'b1, Cpb);
      tick(20);
      wait_obs(1, "after_framing");
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); g = obs_q.pop_front();
         tests++; if (g !== e) begin fails++; $display("FAIL after_framing_byte: got %h want %h", g, e); end
      end
   endtask

   task automatic test_reset_midframe();
      int d0, e0;
      logic [7:0] data, e, g;
      tick(50);
      data = 8'hF0;
      rx = 1'b0;
      tick(Cpb);
      for (int i = 0; i < 4; i++) begin
         rx = data[i];
         tick(Cpb);
      end
      rx = data[4];
      tick(Cpb / 2);
      rst = 1'b1;
      #1;
      tests++; if (active !== 1'b0) begin fails++; $display("FAIL midrst_active: got %b want 0", active); end
      tests++; if (rx_byte !== 8'h00) begin fails++; $display("FAIL midrst_byte: got %h want 00", rx_byte); end
      tests++; if (dv !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL midrst_pulses: got dv %b err %b want 0 0", dv, err); end
      tick(5);
      d0 = dv_cnt; e0 = err_cnt;
      rst = 1'b0;
      rx = 1'b1;
      tick(1000);
      tests++; if (dv_cnt != d0 || err_cnt != e0) begin
         fails++; $display("FAIL midrst_no_pulse: got dv %0d err %0d want 0 0", dv_cnt - d0, err_cnt - e0);
      end
      send_frame(8'h96, 1'b1, Cpb);
      tick(20);
      wait_obs(1, "after_reset");
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); g = obs_q.pop_front();
         tests++; if (g !== e) begin fails++; $display("FAIL after_reset_byte: got %h want %h", g, e); end
      end
   endtask

   task automatic test_baud_skew();
      int e0;
      int periods[2];
      logic [7:0] e, g;
      periods[0] = 62;
      periods[1] = 66;
      for (int p = 0; p < 2; p++) begin
         tick(50);
         e0 = err_cnt;
         send_frame(8'hC3, 1'b1, periods[p]);
         tick(40);
         wait_obs(1, "skew");
         while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front();
            tests++; if (g !== e) begin fails++; $display("FAIL skew_byte_%0d: got %h want %h", periods[p], g, e); end
         end
         tests++; if (err_cnt != e0) begin fails++; $display("FAIL skew_err_%0d: got %0d want 0", periods[p], err_cnt - e0); end
      end
   endtask

   task automatic test_exclusive();
      tests++; if (overlap_cnt != 0) begin fails++; $display("FAIL dv_err_overlap: got %0d want 0", overlap_cnt); end
      tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL unexpected_bytes: got %0d want 0", obs_q.size()); end
   endtask

   initial begin
      tick(1);
      test_reset();
      test_single();
      test_back_to_back();
      test_false_start();
      test_framing();
      test_reset_midframe();
      test_baud_skew();
      test_exclusive();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
